// File: rtl/icb_periph_split_pkg.sv
// Shared target-id encodings for the peripheral ICB splitter.
package icb_periph_split_pkg;

    localparam int unsigned SPLIT_TGT_W = 2;

    typedef logic [SPLIT_TGT_W-1:0] split_tgt_t;

    localparam split_tgt_t SPLIT_TGT_S0  = 2'd0;
    localparam split_tgt_t SPLIT_TGT_S1  = 2'd1;
    localparam split_tgt_t SPLIT_TGT_ERR = 2'd2;

endpackage

// File: rtl/icb_ots_fifo.sv
// Small synchronous FIFO tracking the target id of each outstanding command.
// Pointers carry one wrap bit above the index so full and empty are distinguishable.
module icb_ots_fifo #(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [Width-1:0] wdata,
    input  logic             pop,
    output logic [Width-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned IW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0] mem [2**IW];
    logic [IW:0]      wr_ptr;
    logic [IW:0]      rd_ptr;
    logic [IW:0]      used;

    assign used  = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (used == (IW+1)'(Depth));
    assign rdata = mem[rd_ptr[IW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[IW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/icb_periph_split.sv
// 1-to-2 ICB splitter in front of the CLINT with in-order response return.
// Define ICB_SPLIT_DECERR_EN to answer unmapped addresses with an internal error response.
module icb_periph_split
    import icb_periph_split_pkg::*;
#(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned OTS     = 2,
    parameter logic [7:0]  S0_BASE = 8'h02,
    parameter logic [7:0]  S1_BASE = 8'h0C
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            m_cmd_valid,
    output logic            m_cmd_ready,
    input  logic [AW-1:0]   m_cmd_addr,
    input  logic            m_cmd_read,
    input  logic [DW-1:0]   m_cmd_wdata,
    input  logic [DW/8-1:0] m_cmd_wmask,
    input  logic [1:0]      m_cmd_size,
    output logic            m_rsp_valid,
    input  logic            m_rsp_ready,
    output logic            m_rsp_err,
    output logic [DW-1:0]   m_rsp_rdata,
    output logic            s0_cmd_valid,
    input  logic            s0_cmd_ready,
    output logic [AW-1:0]   s0_cmd_addr,
    output logic            s0_cmd_read,
    output logic [DW-1:0]   s0_cmd_wdata,
    output logic [DW/8-1:0] s0_cmd_wmask,
    output logic [1:0]      s0_cmd_size,
    input  logic            s0_rsp_valid,
    output logic            s0_rsp_ready,
    input  logic            s0_rsp_err,
    input  logic [DW-1:0]   s0_rsp_rdata,
    output logic            s1_cmd_valid,
    input  logic            s1_cmd_ready,
    output logic [AW-1:0]   s1_cmd_addr,
    output logic            s1_cmd_read,
    output logic [DW-1:0]   s1_cmd_wdata,
    output logic [DW/8-1:0] s1_cmd_wmask,
    output logic [1:0]      s1_cmd_size,
    input  logic            s1_rsp_valid,
    output logic            s1_rsp_ready,
    input  logic            s1_rsp_err,
    input  logic [DW-1:0]   s1_rsp_rdata
);

    split_tgt_t tgt;
    split_tgt_t last_tgt;
    split_tgt_t head;
    logic       fifo_full;
    logic       fifo_empty;
    logic       accept_ok;
    logic       sel_ready;
    logic       push;
    logic       pop;

    always_comb begin
        if (m_cmd_addr[AW-1:AW-8] == S0_BASE) begin
            tgt = SPLIT_TGT_S0;
        end else if (m_cmd_addr[AW-1:AW-8] == S1_BASE) begin
            tgt = SPLIT_TGT_S1;
        end else begin
`ifdef ICB_SPLIT_DECERR_EN
            tgt = SPLIT_TGT_ERR;
`else
            tgt = SPLIT_TGT_S1;
`endif
        end
    end

    // Switching targets waits for a full drain so responses can never overtake each other.
    assign accept_ok = rst & !fifo_full & (fifo_empty | (tgt == last_tgt));

    always_comb begin
        sel_ready = 1'b0;
        case (tgt)
            SPLIT_TGT_S0:  sel_ready = s0_cmd_ready;
            SPLIT_TGT_S1:  sel_ready = s1_cmd_ready;
`ifdef ICB_SPLIT_DECERR_EN
            SPLIT_TGT_ERR: sel_ready = 1'b1;
`endif
            default:       sel_ready = 1'b0;
        endcase
    end

    assign m_cmd_ready  = accept_ok & sel_ready;
    assign s0_cmd_valid = m_cmd_valid & (tgt == SPLIT_TGT_S0) & accept_ok;
    assign s1_cmd_valid = m_cmd_valid & (tgt == SPLIT_TGT_S1) & accept_ok;

    assign s0_cmd_addr  = m_cmd_addr;
    assign s0_cmd_read  = m_cmd_read;
    assign s0_cmd_wdata = m_cmd_wdata;
    assign s0_cmd_wmask = m_cmd_wmask;
    assign s0_cmd_size  = m_cmd_size;
    assign s1_cmd_addr  = m_cmd_addr;
    assign s1_cmd_read  = m_cmd_read;
    assign s1_cmd_wdata = m_cmd_wdata;
    assign s1_cmd_wmask = m_cmd_wmask;
    assign s1_cmd_size  = m_cmd_size;

    assign push = m_cmd_valid & m_cmd_ready;
    assign pop  = m_rsp_valid & m_rsp_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_tgt <= SPLIT_TGT_S0;
        end else if (push) begin
            last_tgt <= tgt;
        end
    end

    icb_ots_fifo #(
        .Depth (OTS),
        .Width (SPLIT_TGT_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (tgt),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        m_rsp_valid  = 1'b0;
        m_rsp_err    = 1'b0;
        m_rsp_rdata  = '0;
        s0_rsp_ready = 1'b0;
        s1_rsp_ready = 1'b0;
        if (!fifo_empty) begin
            case (head)
                SPLIT_TGT_S0: begin
                    m_rsp_valid  = s0_rsp_valid;
                    m_rsp_err    = s0_rsp_err;
                    m_rsp_rdata  = s0_rsp_rdata;
                    s0_rsp_ready = m_rsp_ready;
                end
                SPLIT_TGT_S1: begin
                    m_rsp_valid  = s1_rsp_valid;
                    m_rsp_err    = s1_rsp_err;
                    m_rsp_rdata  = s1_rsp_rdata;
                    s1_rsp_ready = m_rsp_ready;
                end
`ifdef ICB_SPLIT_DECERR_EN
                SPLIT_TGT_ERR: begin
                    m_rsp_valid = 1'b1;
                    m_rsp_err   = 1'b1;
                end
`endif
                default: begin
                    m_rsp_valid = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icb_periph_split.sv
// Directed bench for icb_periph_split: routing, drain-before-switch, full stall,
// in-order response steering, unmapped decode and mid-transaction reset.
module tb_icb_periph_split;

    logic        clk;
    logic        rst;
    logic        m_cmd_valid;
    logic        m_cmd_ready;
    logic [31:0] m_cmd_addr;
    logic        m_cmd_read;
    logic [31:0] m_cmd_wdata;
    logic [3:0]  m_cmd_wmask;
    logic [1:0]  m_cmd_size;
    logic        m_rsp_valid;
    logic        m_rsp_ready;
    logic        m_rsp_err;
    logic [31:0] m_rsp_rdata;
    logic        s0_cmd_valid, s0_cmd_ready, s0_cmd_read;
    logic [31:0] s0_cmd_addr, s0_cmd_wdata;
    logic [3:0]  s0_cmd_wmask;
    logic [1:0]  s0_cmd_size;
    logic        s0_rsp_valid, s0_rsp_ready, s0_rsp_err;
    logic [31:0] s0_rsp_rdata;
    logic        s1_cmd_valid, s1_cmd_ready, s1_cmd_read;
    logic [31:0] s1_cmd_addr, s1_cmd_wdata;
    logic [3:0]  s1_cmd_wmask;
    logic [1:0]  s1_cmd_size;
    logic        s1_rsp_valid, s1_rsp_ready, s1_rsp_err;
    logic [31:0] s1_rsp_rdata;

    int checks = 0;
    int errors = 0;

    icb_periph_split dut (
        .clk          (clk),
        .rst          (rst),
        .m_cmd_valid  (m_cmd_valid),
        .m_cmd_ready  (m_cmd_ready),
        .m_cmd_addr   (m_cmd_addr),
        .m_cmd_read   (m_cmd_read),
        .m_cmd_wdata  (m_cmd_wdata),
        .m_cmd_wmask  (m_cmd_wmask),
        .m_cmd_size   (m_cmd_size),
        .m_rsp_valid  (m_rsp_valid),
        .m_rsp_ready  (m_rsp_ready),
        .m_rsp_err    (m_rsp_err),
        .m_rsp_rdata  (m_rsp_rdata),
        .s0_cmd_valid (s0_cmd_valid),
        .s0_cmd_ready (s0_cmd_ready),
        .s0_cmd_addr  (s0_cmd_addr),
        .s0_cmd_read  (s0_cmd_read),
        .s0_cmd_wdata (s0_cmd_wdata),
        .s0_cmd_wmask (s0_cmd_wmask),
        .s0_cmd_size  (s0_cmd_size),
        .s0_rsp_valid (s0_rsp_valid),
        .s0_rsp_ready (s0_rsp_ready),
        .s0_rsp_err   (s0_rsp_err),
        .s0_rsp_rdata (s0_rsp_rdata),
        .s1_cmd_valid (s1_cmd_valid),
        .s1_cmd_ready (s1_cmd_ready),
        .s1_cmd_addr  (s1_cmd_addr),
        .s1_cmd_read  (s1_cmd_read),
        .s1_cmd_wdata (s1_cmd_wdata),
        .s1_cmd_wmask (s1_cmd_wmask),
        .s1_cmd_size  (s1_cmd_size),
        .s1_rsp_valid (s1_rsp_valid),
        .s1_rsp_ready (s1_rsp_ready),
        .s1_rsp_err   (s1_rsp_err),
        .s1_rsp_rdata (s1_rsp_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs checked 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic [31:0] addr, input logic rd);
        m_cmd_valid = 1'b1;
        m_cmd_addr  = addr;
        m_cmd_read  = rd;
    endtask

    initial begin
        rst          = 1'b1;
        m_cmd_valid  = 1'b0;
        m_cmd_addr   = '0;
        m_cmd_read   = 1'b1;
        m_cmd_wdata  = '0;
        m_cmd_wmask  = '0;
        m_cmd_size   = 2'd2;
        m_rsp_ready  = 1'b1;
        s0_cmd_ready = 1'b1;
        s1_cmd_ready = 1'b1;
        s0_rsp_valid = 1'b0;
        s0_rsp_err   = 1'b0;
        s0_rsp_rdata = '0;
        s1_rsp_valid = 1'b0;
        s1_rsp_err   = 1'b0;
        s1_rsp_rdata = '0;
        #2 rst = 1'b0;

        // Reset: no command accepted or forwarded even with a valid request
        cmd(32'h0200_0000, 1'b1);
        tick();
        #1;
        chk("rst_cmd_ready", m_cmd_ready, 0);
        chk("rst_s0_valid", s0_cmd_valid, 0);
        chk("rst_rsp_valid", m_rsp_valid, 0);
        m_cmd_valid = 1'b0;
        tick();
        rst = 1'b1;

        // 1: read to s0, response one cycle later
        tick();
        cmd(32'h0200_0000, 1'b1);
        s0_cmd_ready = 1'b0;
        #1;
        chk("t1_ready_follows_slave", m_cmd_ready, 0);
        s0_cmd_ready = 1'b1;
        #1;
        chk("t1_s0_valid", s0_cmd_valid, 1);
        chk("t1_s1_idle", s1_cmd_valid, 0);
        chk("t1_cmd_ready", m_cmd_ready, 1);
        chk("t1_s0_addr", s0_cmd_addr, 32'h0200_0000);
        tick();
        m_cmd_valid  = 1'b0;
        s0_rsp_valid = 1'b1;
        s0_rsp_rdata = 32'h1234;
        #1;
        chk("t1_rsp_valid", m_rsp_valid, 1);
        chk("t1_rsp_rdata", m_rsp_rdata, 32'h1234);
        chk("t1_rsp_err", m_rsp_err, 0);
        chk("t1_s0_rsp_ready", s0_rsp_ready, 1);
        tick();
        s0_rsp_valid = 1'b0;
        #1;
        chk("t1_drained", m_rsp_valid, 0);

        // 2: write to s0 then write to s1 must wait for s0 to drain
        cmd(32'h0200_0008, 1'b0);
        m_cmd_wdata = 32'hCAFE_F00D;
        m_cmd_wmask = 4'hF;
        #1;
        chk("t2_s0_valid", s0_cmd_valid, 1);
        chk("t2_s0_read", s0_cmd_read, 0);
        chk("t2_s0_wdata", s0_cmd_wdata, 32'hCAFE_F00D);
        chk("t2_s0_wmask", s0_cmd_wmask, 4'hF);
        tick();
        cmd(32'h0C00_0004, 1'b0);
        #1;
        chk("t2_switch_stall", m_cmd_ready, 0);
        chk("t2_s1_gated", s1_cmd_valid, 0);
        tick();
        chk("t2_switch_stall2", m_cmd_ready, 0);
        s0_rsp_valid = 1'b1;
        s0_rsp_rdata = 32'h0;
        #1;
        chk("t2_pop_cycle_stall", m_cmd_ready, 0);
        chk("t2_s0_rsp", m_rsp_valid, 1);
        tick();
        s0_rsp_valid = 1'b0;
        #1;
        chk("t2_s1_ready", m_cmd_ready, 1);
        chk("t2_s1_valid", s1_cmd_valid, 1);
        chk("t2_s1_addr", s1_cmd_addr, 32'h0C00_0004);
        tick();
        m_cmd_valid  = 1'b0;
        s1_rsp_valid = 1'b1;
        s1_rsp_err   = 1'b1;
        s1_rsp_rdata = 32'hBEEF;
        #1;
        chk("t2_s1_rsp_err", m_rsp_err, 1);
        chk("t2_s1_rsp_rdata", m_rsp_rdata, 32'hBEEF);
        chk("t2_s1_rsp_ready", s1_rsp_ready, 1);
        tick();
        s1_rsp_valid = 1'b0;
        s1_rsp_err   = 1'b0;

        // 3: fill to OTS=2, third read stalls until the cycle after the first pop
        cmd(32'h0200_0010, 1'b1);
        #1;
        chk("t3_first", m_cmd_ready, 1);
        tick();
        chk("t3_second", m_cmd_ready, 1);
        tick();
        chk("t3_full_stall", m_cmd_ready, 0);
        chk("t3_full_s0_gated", s0_cmd_valid, 0);
        s0_rsp_valid = 1'b1;
        s0_rsp_rdata = 32'hA1;
        #1;
        chk("t3_no_push_on_pop", m_cmd_ready, 0);
        chk("t3_rsp_a1", m_rsp_rdata, 32'hA1);
        tick();
        s0_rsp_valid = 1'b0;
        #1;
        chk("t3_ready_after_pop", m_cmd_ready, 1);
        tick();
        m_cmd_valid  = 1'b0;
        s0_rsp_valid = 1'b1;
        s0_rsp_rdata = 32'hA2;
        #1;
        chk("t3_rsp_a2", m_rsp_rdata, 32'hA2);
        tick();
        s0_rsp_rdata = 32'hA3;
        #1;
        chk("t3_rsp_a3_valid", m_rsp_valid, 1);
        chk("t3_rsp_a3", m_rsp_rdata, 32'hA3);
        tick();
        #1;
        chk("t3_empty_after_wrap", m_rsp_valid, 0);
        s0_rsp_valid = 1'b0;

        // 5: s1 response while head is s0 is ignored
        cmd(32'h0200_0020, 1'b1);
        tick();
        m_cmd_valid  = 1'b0;
        s1_rsp_valid = 1'b1;
        s1_rsp_rdata = 32'h5151;
        #1;
        chk("t5_s1_not_acked", s1_rsp_ready, 0);
        chk("t5_no_rsp", m_rsp_valid, 0);
        tick();
        s0_rsp_valid = 1'b1;
        s0_rsp_rdata = 32'h5050;
        #1;
        chk("t5_s0_data", m_rsp_rdata, 32'h5050);
        chk("t5_s1_still_not_acked", s1_rsp_ready, 0);
        chk("t5_s0_acked", s0_rsp_ready, 1);
        tick();
        s0_rsp_valid = 1'b0;
        s1_rsp_valid = 1'b0;

        // 4: unmapped address
        cmd(32'h4000_0000, 1'b1);
        #1;
        chk("t4_s0_idle", s0_cmd_valid, 0);
        chk("t4_accept", m_cmd_ready, 1);
`ifdef ICB_SPLIT_DECERR_EN
        chk("t4_s1_idle", s1_cmd_valid, 0);
        tick();
        m_cmd_valid = 1'b0;
        #1;
        chk("t4_err_valid", m_rsp_valid, 1);
        chk("t4_err_flag", m_rsp_err, 1);
        chk("t4_err_rdata", m_rsp_rdata, 0);
        tick();
`else
        chk("t4_default_s1", s1_cmd_valid, 1);
        tick();
        m_cmd_valid  = 1'b0;
        s1_rsp_valid = 1'b1;
        s1_rsp_rdata = 32'h4444;
        #1;
        chk("t4_s1_rsp", m_rsp_rdata, 32'h4444);
        tick();
        s1_rsp_valid = 1'b0;
`endif
        #1;
        chk("t4_drained", m_rsp_valid, 0);

        // 6: reset with two outstanding s0 reads
        cmd(32'h0200_0030, 1'b1);
        tick();
        tick();
        m_cmd_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("t6_rst_ready", m_cmd_ready, 0);
        tick();
        rst = 1'b1;
        s0_rsp_valid = 1'b1;
        cmd(32'h0C00_0000, 1'b1);
        #1;
        chk("t6_rsp_discarded", m_rsp_valid, 0);
        chk("t6_s0_rsp_not_acked", s0_rsp_ready, 0);
        chk("t6_s1_accept", m_cmd_ready, 1);
        chk("t6_s1_valid", s1_cmd_valid, 1);
        tick();
        m_cmd_valid  = 1'b0;
        s0_rsp_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/icb_periph_split.md
Name: icb_periph_split

Overview:
- 1-to-2 ICB splitter directly upstream of the CLINT.
- Takes the core's peripheral ICB master port and routes each command by address to slave 0 (CLINT) or slave 1 (PLIC/other peripheral).
- Tracks outstanding transactions in a small in-order FIFO and returns responses to the master in command order.

Parameters:
- AW, 32, address width (MYRISCV_ADDRDW).
- DW, 32, data width (MYRISCV_XLEN); mask width is DW/8.
- OTS, 2, max outstanding commands (FIFO depth, power of 2, >=1).
- S0_BASE, 8'h02, addr[AW-1:AW-8] match value for slave 0 (CLINT at 0x0200_0000).
- S1_BASE, 8'h0C, addr[AW-1:AW-8] match value for slave 1.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- m_cmd_valid/m_cmd_ready  in/out  1/1  master command handshake.
- m_cmd_addr  in  AW  master command address.
- m_cmd_read  in  1  1 = read, 0 = write.
- m_cmd_wdata  in  DW  write data.
- m_cmd_wmask  in  DW/8  byte write mask.
- m_cmd_size  in  2  access size, passed through.
- m_rsp_valid/m_rsp_ready  out/in  1/1  master response handshake.
- m_rsp_err  out  1  response error flag.
- m_rsp_rdata  out  DW  response read data.
- sN_cmd_valid/sN_cmd_ready  out/in  1/1  slave N (N=0,1) command handshake.
- sN_cmd_addr/read/wdata/wmask/size  out  AW/1/DW/DW/8/2  slave N command fields.
- sN_rsp_valid/sN_rsp_ready  in/out  1/1  slave N response handshake.
- sN_rsp_err  in  1  slave N response error flag.
- sN_rsp_rdata  in  DW  slave N response read data.

Behaviour:
- Decode (combinational): tgt = 0 if addr[AW-1:AW-8]==S0_BASE; 1 if ==S1_BASE; else unmapped (see Optional Feature).
- Cmd payload fans out to both slaves unchanged; only sN_cmd_valid is gated: sN_cmd_valid = m_cmd_valid & (tgt==N) & accept_ok.
- accept_ok = !fifo_full & (fifo_empty | tgt==last_tgt).
  - A new target is accepted only after all outstanding responses drain, so there is no reordering.
  - last_tgt is a register updated on every accepted command.
- m_cmd_ready = accept_ok & ready of the selected target; the internal error target is always ready.
- Push: on m_cmd_valid & m_cmd_ready, push tgt into the FIFO.
  - Push is blocked when full, even if a pop occurs in the same cycle.
  - Push and pop in the same cycle are allowed when not full; the count stays unchanged.
- Head: head = FIFO front entry.
  - m_rsp_valid = !fifo_empty & (rsp_valid of head target).
  - sN_rsp_ready = m_rsp_ready & !fifo_empty & head==N; a response from a non-head slave is never acknowledged.
  - m_rsp_rdata/err are muxed from the head target.
- Pop on m_rsp_valid & m_rsp_ready.
- Latency: zero added cycles on both cmd and rsp paths (pure combinational routing plus FIFO bookkeeping).
- Pointers: wr/rd pointers are log2(OTS) bits plus one wrap bit; full = same index and differing wrap bit; empty = equal pointers. Wrap-around is tested explicitly.
- Reset (rst=0):
  - FIFO empty, last_tgt=0, all sN_cmd_valid=0, m_rsp_valid=0, m_cmd_ready=0 until rst deasserts.
  - Reset mid-transaction discards outstanding entries; slaves are reset by the same rst.

Optional Feature:
- Macro ICB_SPLIT_DECERR_EN.
- Defined: unmapped addresses go to internal target 2. It accepts whenever accept_ok holds and pushes id 2. When id 2 is at the head, m_rsp_valid=1, m_rsp_err=1, m_rsp_rdata=0, popped on m_rsp_ready.
- Undefined: unmapped addresses route to slave 1 (default slave); target 2 logic is absent.

Decomposition:
- Shared package/defines file:
  - target id encodings (SPLIT_TGT_S0=0, SPLIT_TGT_S1=1, SPLIT_TGT_ERR=2).
  - target id width (2).
- One sub-module: icb_ots_fifo.
  - Parameterised depth/width sync FIFO with push/pop, full/empty and async active-low reset.
- Splitter top holds decode, gating and muxing.

Test Plan:
1. Read at 0x0200_0000 with s0 rsp 1 cycle later, rdata=0x1234 -> s0_cmd_valid=1, s1 idle, m_rsp_rdata=0x1234, err=0, FIFO empty after.
2. Back-to-back writes at 0x0200_0008 and 0x0C00_0004 -> second cmd stalled (m_cmd_ready=0) until s0 rsp pops, then routed to s1.
3. OTS=2, three reads to s0, s0 rsp_valid held 0 -> third cmd stalled; m_cmd_ready returns high the cycle after the first rsp pops.
4. With ICB_SPLIT_DECERR_EN, read at 0x4000_0000 -> no slave valid; m_rsp_valid=1, err=1, rdata=0. Without the macro -> s1_cmd_valid=1.
5. s1 asserts rsp_valid while the head is s0 -> s1_rsp_ready=0, m_rsp carries s0 data only.
6. Assert rst with 2 outstanding, release -> m_rsp_valid=0, FIFO empty, new cmd to s1 accepted immediately.
